multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles per memory access (legal range 0..15).
REQ-002 SHALL have one clock and a synchronous, active-high reset, named clk and reset; polarity and synchronicity are fixed.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  32  current instruction-register contents.
REQ-006 zero  input  1  rs == rt, for beq.
REQ-007 rs_ge0  input  1  signed rs >= 0, for bgez/bgezal.
REQ-008 pc_write, ir_write, reg_write  output  1 each  write enables.
REQ-009 mem_write  output  2  00 none, 01 word, 10 half, 11 byte.
REQ-010 mem_to_reg  output  2  00 ALU, 01 memory, 10 PC+4 link.
REQ-011 reg_dst  output  2  00 rt, 01 rd, 10 $31.
REQ-012 alu_ctr  output  3  001 or, 010 add, 011 sub, 100 srav, 101 other.
REQ-013 alu_src  output  1  1 selects the extended immediate.
REQ-014 pc_src  output  3  000 PC+4, 001 branch, 010 rs, 011 jump target.
REQ-015 ext_op  output  2  00 sign, 01 zero, 10 upper (lui), 11 other.
REQ-016 ld_type  output  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
REQ-017 state  output  3  current FSM state.
REQ-018 instr_done  output  1  one-cycle pulse on the last cycle of every instruction.
REQ-019 illegal  output  1  one-cycle pulse for an undecoded instruction.

Function
REQ-020 SHALL decode addu, subu, srav, ori, lui, beq, lw, lh, lhu, lb, lbu, sw, sh, sb, j, jal, jr, jalr, bgez (op 000001, rt 00001) and bgezal (op 000001, rt 10001); instr == 0 is nop.
REQ-021 Static fields (alu_ctr, alu_src, reg_dst, mem_to_reg, ext_op, ld_type, pc_src) SHALL be combinational from instr in every state; write enables SHALL assert only as stated below.
REQ-022 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5..7 SHALL go to FETCH on the next cycle with all enables 0.
REQ-023 FETCH: a wait counter SHALL count 0..MEM_WAIT; on the final count ir_write=1, pc_write=1, pc_src=000, and the FSM goes to DECODE.
REQ-024 DECODE for j/jal: pc_write=1, pc_src=011; for jr/jalr: pc_write=1, pc_src=010; jal/jalr additionally reg_write=1, mem_to_reg=10; FSM goes to FETCH.
REQ-025 DECODE for beq: pc_write = zero; for bgez/bgezal: pc_write = rs_ge0; pc_src=001 in both cases; bgezal reg_write=1 regardless of rs_ge0; FSM goes to FETCH.
REQ-026 DECODE for nop or illegal: no enables, goes to FETCH; illegal=1 for that cycle only.
REQ-027 DECODE for ALU, load or store instructions SHALL go to EXEC.
REQ-028 EXEC: no enables; ALU instructions go to WB, loads and stores go to MEM.
REQ-029 MEM: counter counts 0..MEM_WAIT; on the final count a store asserts mem_write (its code) and goes to FETCH, and a load goes to WB; mem_write SHALL be 00 on non-final cycles.
REQ-030 WB: reg_write=1, then goes to FETCH.
REQ-031 instr_done SHALL be 1 on each transition into FETCH from DECODE, MEM or WB.
REQ-032 The wait counter SHALL be $clog2(MEM_WAIT+1) bits wide (minimum 1), cleared on every state change, and never wrap.
REQ-033 zero and rs_ge0 SHALL be sampled only in DECODE.

Reset
REQ-034 While reset=1 at a rising edge: state SHALL become FETCH, counter 0; all enables, instr_done and illegal SHALL be 0 in the reset cycle.
REQ-035 Reset asserted mid-instruction SHALL abandon it with no further enable pulses.

Verification
REQ-036 MEM_WAIT=0, addu 0x00221821 -> states 0,1,2,4; reg_write=1 only in WB; reg_dst=01, alu_ctr=010; 4 cycles.
REQ-037 MEM_WAIT=2, lw 0x8C220004 -> FETCH 3 cycles, DECODE, EXEC, MEM 3 cycles, WB; 9 cycles total; ld_type=000, mem_to_reg=01.
REQ-038 beq 0x10220003 with zero=1 -> pc_write=1, pc_src=001 in DECODE; with zero=0 -> pc_write=0; both cases 2 cycles at MEM_WAIT=0.
REQ-039 jal 0x0C000010 -> in DECODE: pc_write=1, pc_src=011, reg_write=1, reg_dst=10, mem_to_reg=10; instr_done=1.
REQ-040 0xFC000000 -> illegal=1 in DECODE for one cycle, no enables, then FETCH.
REQ-041 MEM_WAIT=3, sw 0xAC220000, reset asserted on the 2nd MEM cycle -> mem_write stays 00 throughout; state=FETCH and counter=0 on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: instruction decode plus a FETCH/DECODE/EXEC/MEM/WB
// sequencer with MEM_WAIT extra wait cycles on every memory access.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        rs_ge0,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  mem_write,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  reg_dst,
  output logic [2:0]  alu_ctr,
  output logic        alu_src,
  output logic [2:0]  pc_src,
  output logic [1:0]  ext_op,
  output logic [2:0]  ld_type,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal
);

  // state  | meaning
  // FETCH  | instruction read, waits MEM_WAIT extra cycles, loads IR and PC+4
  // DECODE | jumps/branches complete here, others move on to EXEC
  // EXEC   | ALU operation or address calculation
  // MEM    | data access, waits MEM_WAIT extra cycles; stores complete here
  // WB     | register file write
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT);

  state_t        state_q;
  logic [CW-1:0] cnt;
  logic          cnt_last;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic is_rtype, is_nop;
  logic i_addu, i_subu, i_srav, i_jr, i_jalr;
  logic i_ori, i_lui, i_beq, i_j, i_jal, i_bgez, i_bgezal;
  logic i_lw, i_lh, i_lhu, i_lb, i_lbu, i_sw, i_sh, i_sb;
  logic is_alu, is_load, is_store, is_jump, is_jreg, is_bgez_any, is_link;
  logic exec_path, legal;
  logic [2:0] pc_src_dec;
  logic [1:0] st_code;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];

  assign is_nop   = (instr == 32'd0);
  assign is_rtype = (op == 6'b000000);
  assign i_addu   = is_rtype && (funct == 6'b100001);
  assign i_subu   = is_rtype && (funct == 6'b100011);
  assign i_srav   = is_rtype && (funct == 6'b000111);
  assign i_jr     = is_rtype && (funct == 6'b001000);
  assign i_jalr   = is_rtype && (funct == 6'b001001);
  assign i_ori    = (op == 6'b001101);
  assign i_lui    = (op == 6'b001111);
  assign i_beq    = (op == 6'b000100);
  assign i_j      = (op == 6'b000010);
  assign i_jal    = (op == 6'b000011);
  assign i_bgez   = (op == 6'b000001) && (rt == 5'b00001);
  assign i_bgezal = (op == 6'b000001) && (rt == 5'b10001);
  assign i_lw     = (op == 6'b100011);
  assign i_lh     = (op == 6'b100001);
  assign i_lhu    = (op == 6'b100101);
  assign i_lb     = (op == 6'b100000);
  assign i_lbu    = (op == 6'b100100);
  assign i_sw     = (op == 6'b101011);
  assign i_sh     = (op == 6'b101001);
  assign i_sb     = (op == 6'b101000);

  assign is_alu      = i_addu | i_subu | i_srav | i_ori | i_lui;
  assign is_load     = i_lw | i_lh | i_lhu | i_lb | i_lbu;
  assign is_store    = i_sw | i_sh | i_sb;
  assign is_jump     = i_j | i_jal;
  assign is_jreg     = i_jr | i_jalr;
  assign is_bgez_any = i_bgez | i_bgezal;
  assign is_link     = i_jal | i_jalr | i_bgezal;
  assign exec_path   = is_alu | is_load | is_store;
  assign legal       = exec_path | is_jump | is_jreg | i_beq | is_bgez_any | is_nop;

  assign cnt_last = (cnt == CNT_LAST);
  assign state    = state_q;

  always_comb begin
    alu_ctr    = 3'b101;
    alu_src    = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    ext_op     = 2'b11;
    ld_type    = 3'b000;
    pc_src_dec = 3'b000;
    st_code    = 2'b00;

    if (i_addu || is_load || is_store) alu_ctr = 3'b010;
    else if (i_subu || i_beq)          alu_ctr = 3'b011;
    else if (i_srav)                   alu_ctr = 3'b100;
    else if (i_ori || i_lui)           alu_ctr = 3'b001;

    alu_src = i_ori | i_lui | is_load | is_store;

    if (i_addu || i_subu || i_srav || i_jalr) reg_dst = 2'b01;
    else if (i_jal || i_bgezal)               reg_dst = 2'b10;

    if (is_load)      mem_to_reg = 2'b01;
    else if (is_link) mem_to_reg = 2'b10;

    if (i_ori)                                              ext_op = 2'b01;
    else if (i_lui)                                         ext_op = 2'b10;
    else if (is_load || is_store || i_beq || is_bgez_any)   ext_op = 2'b00;

    if (i_lh)       ld_type = 3'b001;
    else if (i_lhu) ld_type = 3'b010;
    else if (i_lb)  ld_type = 3'b011;
    else if (i_lbu) ld_type = 3'b100;

    if (is_jump)                   pc_src_dec = 3'b011;
    else if (is_jreg)              pc_src_dec = 3'b010;
    else if (i_beq || is_bgez_any) pc_src_dec = 3'b001;

    if (i_sw)      st_code = 2'b01;
    else if (i_sh) st_code = 2'b10;
    else if (i_sb) st_code = 2'b11;
  end

  // Enables decode from the current state so branch conditions are seen live in DECODE.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    pc_src     = (state_q == S_FETCH) ? 3'b000 : pc_src_dec;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (cnt_last) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (is_jump || is_jreg) pc_write = 1'b1;
          if (i_beq)              pc_write = zero;
          if (is_bgez_any)        pc_write = rs_ge0;
          reg_write  = is_link;
          illegal    = !legal;
          instr_done = !exec_path;
        end
        S_MEM: begin
          if (cnt_last && is_store) begin
            mem_write  = st_code;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (cnt_last) begin
            state_q <= S_DECODE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= exec_path ? S_EXEC : S_FETCH;
          cnt     <= '0;
        end
        S_EXEC: begin
          state_q <= is_alu ? S_WB : S_MEM;
          cnt     <= '0;
        end
        S_MEM: begin
          if (cnt_last) begin
            state_q <= is_load ? S_WB : S_FETCH;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt     <= '0;
        end
        default: begin
          state_q <= S_FETCH;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the bench plays IR/datapath, issues random
// mnemonics, and compares each completed instruction against a mnemonic-level model.
module tb_multicycle_ctrl;
  localparam int MW = 2;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        rs_ge0;
  logic        pc_write, ir_write, reg_write, alu_src, instr_done, illegal;
  logic [1:0]  mem_write, mem_to_reg, reg_dst, ext_op;
  logic [2:0]  alu_ctr, pc_src, ld_type, state;

  multicycle_ctrl #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .rs_ge0(rs_ge0),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_ctr(alu_ctr), .alu_src(alu_src), .pc_src(pc_src), .ext_op(ext_op),
    .ld_type(ld_type), .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mnemonic ids
  localparam int ADDU=0, SUBU=1, SRAV=2, ORI=3, LUI=4, BEQ=5, LW=6, LH=7, LHU=8, LB=9,
                 LBU=10, SW=11, SH=12, SB=13, J=14, JAL=15, JR=16, JALR=17, BGEZ=18,
                 BGEZAL=19, NOP=20, ILL=21;

  typedef struct {
    logic [31:0] instr;
    bit          z;
    bit          r;
    int          id;
  } stim_t;

  typedef struct {
    int     cycles;
    longint seq;
    int     pcw;
    int     pcsrc;
    int     regw;
    int     m2r;
    int     dst;
    int     memn;
    int     memw;
    int     ld;
    int     ill;
    int     alu;
    int     asrc;
    int     ext;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] build(input int id);
    logic [31:0] r;
    r = $urandom;
    case (id)
      ADDU:   return {6'b000000, r[25:6], 6'b100001};
      SUBU:   return {6'b000000, r[25:6], 6'b100011};
      SRAV:   return {6'b000000, r[25:6], 6'b000111};
      JR:     return {6'b000000, r[25:6], 6'b001000};
      JALR:   return {6'b000000, r[25:6], 6'b001001};
      ORI:    return {6'b001101, r[25:0]};
      LUI:    return {6'b001111, r[25:0]};
      BEQ:    return {6'b000100, r[25:0]};
      LW:     return {6'b100011, r[25:0]};
      LH:     return {6'b100001, r[25:0]};
      LHU:    return {6'b100101, r[25:0]};
      LB:     return {6'b100000, r[25:0]};
      LBU:    return {6'b100100, r[25:0]};
      SW:     return {6'b101011, r[25:0]};
      SH:     return {6'b101001, r[25:0]};
      SB:     return {6'b101000, r[25:0]};
      J:      return {6'b000010, r[25:0]};
      JAL:    return {6'b000011, r[25:0]};
      BGEZ:   return {6'b000001, r[25:21], 5'b00001, r[15:0]};
      BGEZAL: return {6'b000001, r[25:21], 5'b10001, r[15:0]};
      NOP:    return 32'd0;
      default: begin
        case ($urandom_range(0, 3))
          0:       return {6'b111111, r[25:0]};
          1:       return {6'b000000, r[25:6], 6'b100100};
          2:       return {6'b000001, r[25:21], 5'b00000, r[15:0]};
          default: return {6'b001000, r[25:0]};
        endcase
      end
    endcase
  endfunction

  function automatic void add_st(inout exp_t e, input int st, input int n);
    for (int k = 0; k < n; k++) begin
      e.seq = (e.seq << 3) | longint'(st);
      e.cycles++;
    end
  endfunction

  // Per-instruction outcome from the mnemonic and its branch condition only.
  function automatic exp_t model(input int id, input bit z, input bit r);
    exp_t e;
    e.cycles = 0; e.seq = 0; e.pcw = 1; e.pcsrc = 0; e.regw = 0; e.m2r = -1; e.dst = -1;
    e.memn = 0; e.memw = 0; e.ld = -1; e.ill = 0; e.alu = -1; e.asrc = -1; e.ext = -1;
    add_st(e, 0, MW + 1);
    add_st(e, 1, 1);
    if (id <= LUI) begin
      add_st(e, 2, 1); add_st(e, 4, 1);
      e.regw = 1; e.m2r = 0;
      e.dst  = (id <= SRAV) ? 1 : 0;
      e.asrc = (id <= SRAV) ? 0 : 1;
      case (id)
        ADDU: e.alu = 2;
        SUBU: e.alu = 3;
        SRAV: e.alu = 4;
        ORI:  begin e.alu = 1; e.ext = 1; end
        default: e.ext = 2;
      endcase
    end else if (id >= LW && id <= LBU) begin
      add_st(e, 2, 1); add_st(e, 3, MW + 1); add_st(e, 4, 1);
      e.regw = 1; e.m2r = 1; e.dst = 0; e.ld = id - LW;
      e.alu = 2; e.asrc = 1; e.ext = 0;
    end else if (id >= SW && id <= SB) begin
      add_st(e, 2, 1); add_st(e, 3, MW + 1);
      e.memn = 1; e.memw = id - SW + 1;
      e.alu = 2; e.asrc = 1; e.ext = 0;
    end else if (id == J || id == JAL) begin
      e.pcw = 2; e.pcsrc = 3;
      if (id == JAL) begin e.regw = 1; e.m2r = 2; e.dst = 2; end
    end else if (id == JR || id == JALR) begin
      e.pcw = 2; e.pcsrc = 2;
      if (id == JALR) begin e.regw = 1; e.m2r = 2; end
    end else if (id == BEQ) begin
      e.pcw = z ? 2 : 1; e.pcsrc = z ? 1 : 0;
    end else if (id == BGEZ || id == BGEZAL) begin
      e.pcw = r ? 2 : 1; e.pcsrc = r ? 1 : 0;
      if (id == BGEZAL) begin e.regw = 1; e.m2r = 2; e.dst = 2; end
    end else if (id == ILL) begin
      e.ill = 1;
    end
    return e;
  endfunction

  // IR / branch-condition driver: loads the next instruction whenever ir_write is seen.
  initial begin
    bit    ld;
    stim_t s;
    instr = 32'd0; zero = 1'b0; rs_ge0 = 1'b0;
    forever begin
      @(negedge clk);
      ld = ir_write && !reset;
      @(posedge clk);
      #1;
      if (ld) begin
        if (stim_q.size() > 0) s = stim_q.pop_front();
        else s = '{32'd0, 1'b0, 1'b0, NOP};
        instr = s.instr; zero = s.z; rs_ge0 = s.r;
        if (mon_en) exp_q.push_back(model(s.id, s.z, s.r));
      end else begin
        zero   = 1'($urandom);
        rs_ge0 = 1'($urandom);
      end
    end
  end

  // Monitor: accumulate one instruction's activity, compare on instr_done.
  int     a_cyc, a_pcw, a_regw, a_memn, a_ill, a_irw, a_fpc, a_pcsrc, a_m2r, a_dst, a_memw, a_ld;
  longint a_seq;

  function automatic void clr_acc();
    a_cyc = 0; a_pcw = 0; a_regw = 0; a_memn = 0; a_ill = 0; a_irw = 0; a_fpc = 0;
    a_pcsrc = 0; a_m2r = 0; a_dst = 0; a_memw = 0; a_ld = 0; a_seq = 0;
  endfunction

  initial begin
    exp_t e;
    clr_acc();
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        clr_acc();
      end else begin
        a_cyc++;
        a_seq = (a_seq << 3) | longint'(state);
        if (pc_write) begin a_pcw++; a_pcsrc = int'(pc_src); end
        if (ir_write) begin a_irw++; a_fpc = int'(pc_src); end
        if (reg_write) begin
          a_regw++; a_m2r = int'(mem_to_reg); a_dst = int'(reg_dst); a_ld = int'(ld_type);
        end
        if (mem_write != 2'b00) begin a_memn++; a_memw = int'(mem_write); end
        if (illegal) a_ill++;
        if (instr_done) begin
          chk("exp_pending", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycles", a_cyc, e.cycles);
            chk("state_seq", a_seq, e.seq);
            chk("pc_write_cnt", a_pcw, e.pcw);
            chk("pc_src_last", a_pcsrc, e.pcsrc);
            chk("ir_write_cnt", a_irw, 1);
            chk("fetch_pc_src", a_fpc, 0);
            chk("reg_write_cnt", a_regw, e.regw);
            chk("mem_write_cnt", a_memn, e.memn);
            chk("mem_write_code", a_memw, e.memw);
            chk("illegal_cnt", a_ill, e.ill);
            if (e.regw > 0 && e.m2r >= 0) chk("mem_to_reg", a_m2r, e.m2r);
            if (e.regw > 0 && e.dst >= 0) chk("reg_dst", a_dst, e.dst);
            if (e.ld >= 0)   chk("ld_type", a_ld, e.ld);
            if (e.alu >= 0)  chk("alu_ctr", alu_ctr, e.alu);
            if (e.asrc >= 0) chk("alu_src", alu_src, e.asrc);
            if (e.ext >= 0)  chk("ext_op", ext_op, e.ext);
          end
          clr_acc();
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    n;
    bit    saw_mw;
    reset = 1'b1;

    @(posedge clk);
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_outputs", {pc_write, ir_write, reg_write, mem_write, instr_done, illegal}, 0);

    stim_q.push_back('{32'h00221821, 1'b0, 1'b0, ADDU});
    stim_q.push_back('{32'h8C220004, 1'b0, 1'b0, LW});
    stim_q.push_back('{32'h10220003, 1'b1, 1'b0, BEQ});
    stim_q.push_back('{32'h10220003, 1'b0, 1'b1, BEQ});
    stim_q.push_back('{32'h0C000010, 1'b0, 1'b0, JAL});
    stim_q.push_back('{32'hFC000000, 1'b0, 1'b0, ILL});
    stim_q.push_back('{32'hAC220000, 1'b0, 1'b0, SW});
    for (int i = 0; i < 200; i++) begin
      s.id    = $urandom_range(0, 21);
      s.instr = build(s.id);
      s.z     = 1'($urandom);
      s.r     = 1'($urandom);
      stim_q.push_back(s);
    end

    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (stim_q.size() == 0 && exp_q.size() == 0) break;
    end
    chk("drained", longint'(stim_q.size() + exp_q.size()), 0);
    mon_en = 1'b0;

    // Abandon a store partway through MEM with a reset.
    saw_mw = 1'b0;
    stim_q.push_back('{32'hAC220000, 1'b0, 1'b0, SW});
    stim_q.push_back('{32'h00000000, 1'b0, 1'b0, NOP});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_write != 2'b00) saw_mw = 1'b1;
      if (state == 3'd3) break;
    end
    chk("reached_mem", state, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    if (mem_write != 2'b00) saw_mw = 1'b1;
    chk("rst_cycle_outputs", {pc_write, ir_write, reg_write, mem_write, instr_done, illegal}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("state_after_rst", state, 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_write != 2'b00) saw_mw = 1'b1;
      if (state != 3'd0) break;
      n++;
      @(negedge clk);
    end
    chk("fetch_len_after_rst", n, MW + 1);
    chk("decode_after_fetch", state, 1);
    chk("no_mem_write_on_abort", saw_mw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
